// File: rtl/csa_op_sequencer.sv
// Self-checking operand initiator for the top_CSA adder/subtractor: LFSR operands, golden compare, pass/fail tally.
// Optional first-failure capture ports are built when CSA_SEQ_FIRST_FAIL_EN is defined.
module csa_op_sequencer #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned NUM_OPS = 16,
    parameter int unsigned TIMEOUT = 15,
    parameter logic [63:0] SEED    = 64'h1D872B41C0FFEE01
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    output logic [WIDTH-1:0] ope1,
    output logic [WIDTH-1:0] ope2,
    output logic             add_sub,
    output logic             start,
    input  logic [WIDTH-1:0] sum,
    input  logic             complete,
    input  logic             cout,
    input  logic             overf,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pass_count,
    output logic [15:0]      fail_count,
    output logic             timeout_err
`ifdef CSA_SEQ_FIRST_FAIL_EN
    ,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_ope1,
    output logic [WIDTH-1:0] fail_ope2,
    output logic [WIDTH-1:0] fail_sum,
    output logic             fail_add_sub
`endif
);

    // state | meaning
    // IDLE  | waiting for run
    // ISSUE | start pulse, operands valid, golden registered
    // WAIT  | waiting for complete or timer terminal count
    // CHECK | compare captured result with golden, tally
    // DONE  | run finished, held until run drops
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_OPS - 1);
    localparam logic [7:0]  TMR_LOAD = 8'(TIMEOUT - 1);

    state_t state, state_nx;

    logic [63:0]      lfsr_a, lfsr_b;
    logic [15:0]      op_idx;
    logic [7:0]       tmr;
    logic [WIDTH-1:0] gold_sum, cap_sum;
    logic             gold_cout, gold_ovf;
    logic             cap_cout, cap_ovf, cap_to;

    logic [WIDTH-1:0] opb_eff;
    logic [WIDTH:0]   gold_wide;
    logic             gold_ovf_c;
    logic             op_ok;
    logic             tmr_tc;
    logic             last_op;
    logic             new_run;

    always_comb begin
        opb_eff    = add_sub ? ~ope2 : ope2;
        gold_wide  = {1'b0, ope1} + {1'b0, opb_eff} + {{WIDTH{1'b0}}, add_sub};
        gold_ovf_c = (ope1[WIDTH-1] == opb_eff[WIDTH-1]) &&
                     (gold_wide[WIDTH-1] != ope1[WIDTH-1]);
        op_ok      = !cap_to && (cap_sum == gold_sum) &&
                     (cap_cout == gold_cout) && (cap_ovf == gold_ovf);
        tmr_tc     = (tmr == 8'd0);
        last_op    = (op_idx >= LAST_IDX);
        new_run    = (state == S_IDLE) && run;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start    = 1'b1;
                busy     = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (complete || tmr_tc) begin
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                busy     = 1'b1;
                state_nx = last_op ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done = 1'b1;
                if (!run) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operands are latched on entry to ISSUE so they stay stable while the LFSRs advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_a      <= SEED;
            lfsr_b      <= ~SEED;
            op_idx      <= 16'd0;
            tmr         <= 8'd0;
            ope1        <= '0;
            ope2        <= '0;
            add_sub     <= 1'b0;
            gold_sum    <= '0;
            gold_cout   <= 1'b0;
            gold_ovf    <= 1'b0;
            cap_sum     <= '0;
            cap_cout    <= 1'b0;
            cap_ovf     <= 1'b0;
            cap_to      <= 1'b0;
            pass_count  <= 16'd0;
            fail_count  <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            if (new_run) begin
                op_idx     <= 16'd0;
                pass_count <= 16'd0;
                fail_count <= 16'd0;
                ope1       <= lfsr_a[WIDTH-1:0];
                ope2       <= lfsr_b[WIDTH-1:0];
                add_sub    <= 1'b0;
            end

            if (state == S_ISSUE) begin
                lfsr_a    <= {lfsr_a[62:0], lfsr_a[63] ^ lfsr_a[62] ^ lfsr_a[60] ^ lfsr_a[59]};
                lfsr_b    <= {lfsr_b[62:0], lfsr_b[63] ^ lfsr_b[62] ^ lfsr_b[60] ^ lfsr_b[59]};
                tmr       <= TMR_LOAD;
                gold_sum  <= gold_wide[WIDTH-1:0];
                gold_cout <= gold_wide[WIDTH];
                gold_ovf  <= gold_ovf_c;
            end

            if (state == S_WAIT) begin
                if (complete) begin
                    cap_sum  <= sum;
                    cap_cout <= cout;
                    cap_ovf  <= overf;
                    cap_to   <= 1'b0;
                end else if (tmr_tc) begin
                    cap_to      <= 1'b1;
                    timeout_err <= 1'b1;
                end else begin
                    tmr <= tmr - 8'd1;
                end
            end

            if (state == S_CHECK) begin
                if (op_ok) begin
                    pass_count <= (pass_count == 16'hFFFF) ? pass_count : pass_count + 16'd1;
                end else begin
                    fail_count <= (fail_count == 16'hFFFF) ? fail_count : fail_count + 16'd1;
                end
                if (!last_op) begin
                    op_idx  <= op_idx + 16'd1;
                    ope1    <= lfsr_a[WIDTH-1:0];
                    ope2    <= lfsr_b[WIDTH-1:0];
                    add_sub <= ~op_idx[0];
                end
            end
        end
    end

`ifdef CSA_SEQ_FIRST_FAIL_EN
    always_ff @(posedge clock) begin
        if (reset || new_run) begin
            fail_valid   <= 1'b0;
            fail_ope1    <= '0;
            fail_ope2    <= '0;
            fail_sum     <= '0;
            fail_add_sub <= 1'b0;
        end else if ((state == S_CHECK) && !op_ok && !fail_valid) begin
            fail_valid   <= 1'b1;
            fail_ope1    <= ope1;
            fail_ope2    <= ope2;
            fail_sum     <= cap_to ? '0 : cap_sum;
            fail_add_sub <= add_sub;
        end
    end
`endif

endmodule

// File: tb/tb_csa_op_sequencer.sv
// Bench for csa_op_sequencer: behavioural mock adder with fault injection, table-driven runs,
// hand-written reset/run-handshake sequences and randomized runs against a reference model.
module tb_csa_op_sequencer;

    localparam int W    = 64;
    localparam int NOPS = 4;
    localparam int TMO  = 15;
    localparam logic [63:0] SEED = 64'h1D872B41C0FFEE01;

    logic         clock = 1'b0;
    logic         reset;
    logic         run;
    logic [W-1:0] ope1, ope2, sum;
    logic         add_sub, start, complete, cout, overf;
    logic         busy, done, timeout_err;
    logic [15:0]  pass_count, fail_count;
`ifdef CSA_SEQ_FIRST_FAIL_EN
    logic         fail_valid, fail_add_sub;
    logic [W-1:0] fail_ope1, fail_ope2, fail_sum;
`endif

    csa_op_sequencer #(
        .WIDTH(W), .NUM_OPS(NOPS), .TIMEOUT(TMO), .SEED(SEED)
    ) dut (
        .clock(clock), .reset(reset), .run(run),
        .ope1(ope1), .ope2(ope2), .add_sub(add_sub), .start(start),
        .sum(sum), .complete(complete), .cout(cout), .overf(overf),
        .busy(busy), .done(done),
        .pass_count(pass_count), .fail_count(fail_count), .timeout_err(timeout_err)
`ifdef CSA_SEQ_FIRST_FAIL_EN
        ,
        .fail_valid(fail_valid), .fail_ope1(fail_ope1), .fail_ope2(fail_ope2),
        .fail_sum(fail_sum), .fail_add_sub(fail_add_sub)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lfsr_step(input logic [63:0] x);
        return {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
    endfunction

    // Reference result {overflow, carry, sum} from signed/unsigned arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
        logic signed [W+1:0] sa, sb, r, maxs, mins;
        logic [W-1:0] s;
        logic c, o;
        sa   = $signed({{2{a[W-1]}}, a});
        sb   = $signed({{2{b[W-1]}}, b});
        maxs = $signed({3'b000, {(W-1){1'b1}}});
        mins = $signed({3'b111, {(W-1){1'b0}}});
        r    = sub ? sa - sb : sa + sb;
        o    = (r > maxs) || (r < mins);
        s    = sub ? a - b : a + b;
        c    = sub ? (a >= b) : (({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}});
        return {o, c, s};
    endfunction

    // Mock adder configuration: latency in WAIT cycles (0 = never completes), faults per op.
    int cfg_lat[NOPS];
    bit cfg_flip[NOPS];
    bit cfg_inv_sub;

    logic         pend = 1'b0;
    int           wcnt = 0;
    int           cur_lat = 0;
    int           idx = 0;
    int           cyc = 0;
    logic [63:0]  mdl_a = SEED;
    logic [63:0]  mdl_b = ~SEED;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    int           starts[$];
    logic [W-1:0] ops_a[$], ops_b[$], msums[$];

    assign complete = pend && (wcnt == cur_lat);
    assign sum      = m_sum;
    assign cout     = m_cout;
    assign overf    = m_ovf;

    always @(posedge clock) begin : mock_blk
        logic [W+1:0] r;
        logic [W-1:0] s_drv;
        bit fl, iv;
        cyc <= cyc + 1;
        if (reset) begin
            pend    <= 1'b0;
            idx     <= 0;
            wcnt    <= 0;
            cur_lat <= 0;
            mdl_a   <= SEED;
            mdl_b   <= ~SEED;
        end else begin
            if (!busy && !done) idx <= 0;
            if (start) begin
                check($sformatf("ope1_op%0d", idx), ope1, mdl_a[W-1:0]);
                check($sformatf("ope2_op%0d", idx), ope2, mdl_b[W-1:0]);
                check($sformatf("add_sub_op%0d", idx), 64'(add_sub), 64'(idx[0]));
                r     = ref_op(mdl_a[W-1:0], mdl_b[W-1:0], idx[0]);
                fl    = (idx < NOPS) ? cfg_flip[idx] : 1'b0;
                iv    = cfg_inv_sub && idx[0];
                s_drv = r[W-1:0] ^ {{(W-1){1'b0}}, fl};
                m_sum   <= s_drv;
                m_cout  <= r[W];
                m_ovf   <= r[W+1] ^ iv;
                msums.push_back(s_drv);
                ops_a.push_back(ope1);
                ops_b.push_back(ope2);
                starts.push_back(cyc);
                pend    <= 1'b1;
                wcnt    <= 1;
                cur_lat <= (idx < NOPS) ? cfg_lat[idx] : 3;
                mdl_a   <= lfsr_step(mdl_a);
                mdl_b   <= lfsr_step(mdl_b);
                idx     <= idx + 1;
            end else if (pend) begin
                if (complete) pend <= 1'b0;
                else wcnt <= wcnt + 1;
            end
        end
    end

    typedef struct {
        int lat;
        int flip_op;
        bit inv_sub;
        int exp_pass;
        int exp_fail;
        bit exp_to;
        int exp_gap;
    } vec_t;

    vec_t vecs[7];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ope1"}, ope1, 64'd0);
        check({tag, "_ope2"}, ope2, 64'd0);
        check({tag, "_flags"}, 64'({add_sub, start, busy, done, timeout_err}), 64'd0);
        check({tag, "_counts"}, 64'({pass_count, fail_count}), 64'd0);
`ifdef CSA_SEQ_FIRST_FAIL_EN
        check({tag, "_fail_regs"}, 64'(fail_valid) | 64'(fail_add_sub) | fail_ope1 | fail_ope2 | fail_sum, 64'd0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clock);
        starts.delete();
        ops_a.delete();
        ops_b.delete();
        msums.delete();
        run = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done_reached"}, 64'(done), 64'd1);
    endtask

    task automatic release_run(input string tag);
        repeat (3) @(negedge clock);
        check({tag, "_done_held"}, 64'({done, busy}), 64'b10);
        run = 1'b0;
        @(negedge clock);
        check({tag, "_idle_after_run_low"}, 64'({done, busy}), 64'b00);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        string tag;
        tag = $sformatf("vec%0d", k);
        do_reset();
        for (int i = 0; i < NOPS; i++) begin
            cfg_lat[i]  = v.lat;
            cfg_flip[i] = (i == v.flip_op);
        end
        cfg_inv_sub = v.inv_sub;
        start_run();
        wait_done(tag);
        check({tag, "_pass"}, 64'(pass_count), 64'(v.exp_pass));
        check({tag, "_fail"}, 64'(fail_count), 64'(v.exp_fail));
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'(v.exp_to));
        check({tag, "_starts"}, 64'(starts.size()), 64'(NOPS));
        if (starts.size() == NOPS) begin
            for (int i = 1; i < NOPS; i++)
                check($sformatf("%s_gap%0d", tag, i), 64'(starts[i] - starts[i-1]), 64'(v.exp_gap));
        end
`ifdef CSA_SEQ_FIRST_FAIL_EN
        check({tag, "_fail_valid"}, 64'(fail_valid), 64'(v.exp_fail > 0));
        if (v.flip_op >= 0 && ops_a.size() > v.flip_op) begin
            check({tag, "_fail_ope1"}, fail_ope1, ops_a[v.flip_op]);
            check({tag, "_fail_ope2"}, fail_ope2, ops_b[v.flip_op]);
            check({tag, "_fail_sum"}, fail_sum, msums[v.flip_op]);
            check({tag, "_fail_add_sub"}, 64'(fail_add_sub), 64'(v.flip_op % 2));
        end
        if (v.exp_to)
            check({tag, "_fail_sum_timeout"}, fail_sum, 64'd0);
`endif
        release_run(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [W-1:0] saved_first;
        int n;
        int ep, ef;
        bit eto;

        reset = 1'b1;
        run   = 1'b0;
        for (int i = 0; i < NOPS; i++) begin
            cfg_lat[i]  = 3;
            cfg_flip[i] = 1'b0;
        end
        cfg_inv_sub = 1'b0;

        //            lat flip inv pass fail to gap
        vecs[0] = '{ 3, -1, 1'b0, 4, 0, 1'b0,  5};
        vecs[1] = '{ 3,  2, 1'b0, 3, 1, 1'b0,  5};
        vecs[2] = '{ 0, -1, 1'b0, 0, 4, 1'b1, 17};
        vecs[3] = '{15, -1, 1'b0, 4, 0, 1'b0, 17};
        vecs[4] = '{16, -1, 1'b0, 0, 4, 1'b1, 17};
        vecs[5] = '{ 3, -1, 1'b1, 2, 2, 1'b0,  5};
        vecs[6] = '{ 1, -1, 1'b0, 4, 0, 1'b0,  3};

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Reset during WAIT of op 1, then rerun from the reseeded LFSRs.
        do_reset();
        for (int i = 0; i < NOPS; i++) begin
            cfg_lat[i]  = 3;
            cfg_flip[i] = 1'b0;
        end
        cfg_inv_sub = 1'b0;
        start_run();
        n = 0;
        while (starts.size() < 2 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("midwait_second_start", 64'(starts.size()), 64'd2);
        saved_first = (ops_a.size() > 0) ? ops_a[0] : '0;
        check("midwait_in_wait", 64'({busy, start}), 64'b10);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midwait");
        reset = 1'b0;
        starts.delete();
        ops_a.delete();
        ops_b.delete();
        msums.delete();
        wait_done("rerun");
        check("rerun_first_ope1", (ops_a.size() > 0) ? ops_a[0] : '0, saved_first);
        check("rerun_pass", 64'(pass_count), 64'(NOPS));
        release_run("rerun");

        // Randomized back-to-back runs without reset: LFSRs continue, counters restart.
        do_reset();
        eto = 1'b0;
        for (int r = 0; r < 6; r++) begin
            ep = 0;
            ef = 0;
            cfg_inv_sub = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < NOPS; i++) begin
                cfg_lat[i]  = $urandom_range(0, 17);
                cfg_flip[i] = ($urandom_range(0, 3) == 0);
                if (cfg_lat[i] == 0 || cfg_lat[i] > TMO) begin
                    ef++;
                    eto = 1'b1;
                end else if (cfg_flip[i] || (cfg_inv_sub && (i % 2 == 1))) begin
                    ef++;
                end else begin
                    ep++;
                end
            end
            start_run();
            wait_done($sformatf("rand%0d", r));
            check($sformatf("rand%0d_pass", r), 64'(pass_count), 64'(ep));
            check($sformatf("rand%0d_fail", r), 64'(fail_count), 64'(ef));
            check($sformatf("rand%0d_timeout_err", r), 64'(timeout_err), 64'(eto));
`ifdef CSA_SEQ_FIRST_FAIL_EN
            check($sformatf("rand%0d_fail_valid", r), 64'(fail_valid), 64'(ef > 0));
`endif
            release_run($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
